mux_arb_reg: RTL
================

// Module: mux_arb_reg
// PURPOSE
//  Registered SEL-channel x WIDTH-bit multiplexer with valid/ready handshake and built-in arbitration.
//  Successor to the combinational width-generic MUX: it chooses the source itself (fixed-priority or round-robin),
//  holds data under back-pressure and reports which channel it forwarded.
//  Sits between per-channel producers (e.g. RX/WF sample streams) and a single shared consumer (SPI/DMA FIFO).
// PARAMETERS
//  WIDTH   "required"  data bits per channel (>=1)
//  SEL     "required"  number of input channels (>=1)
//  MODE    1           0 = fixed priority (lowest index wins); 1 = round-robin
//  NSEL    localparam  clog2(SEL), forced to 1 when SEL==1
// PORTS
//  clk        in   1          sole clock; all state on posedge
//  rst_n      in   1          asynchronous assert, active-low reset
//  in_data    in   SEL*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
//  in_valid   in   SEL        per-channel data valid
//  in_ready   out  SEL        per-channel accept; one-hot or zero
//  out_data   out  WIDTH      registered selected data
//  out_chan   out  NSEL       channel index of out_data
//  out_valid  out  1          out_data/out_chan valid
//  out_ready  in   1          consumer accept
//  in_last    in   SEL        (MUX_PKT_LOCK_EN only) last beat of packet, per channel
//  out_last   out  1          (MUX_PKT_LOCK_EN only) registered in_last of forwarded beat
// BEHAVIOUR
//  - Reset (rst_n low, async): out_valid=0, out_data=0, out_chan=0, rr_ptr=0, lock=0, out_last=0. in_ready=0 while in reset.
//  - Transfer on a side occurs when valid && ready in the same cycle; source must hold valid/data until accepted.
//  - slot_free = !out_valid || out_ready. Grant g is computed combinationally from in_valid; in_ready[g] = slot_free && in_valid[g].
//  - MODE 0: g = lowest index with in_valid set. MODE 1: search starts at rr_ptr, wraps SEL-1 -> 0, first valid wins.
//  - On input transfer: out_data <= in_data[g], out_chan <= g, out_valid <= 1 next cycle (latency 1 clk).
//  - On output transfer with no input transfer: out_valid <= 0. Both in the same cycle: register reloads, out_valid stays 1.
//    Full throughput of 1 beat/clk.
//  - rr_ptr <= (g==SEL-1) ? 0 : g+1, updated only on input transfer. Unchanged when stalled or idle.
//  - Stall (out_valid && !out_ready): all in_ready=0; out_* held stable, bit-exact.
//  - No valid inputs: in_ready=0; registers unchanged except out_valid clearing per above.
//  - SEL==1: behaves as a 1-deep pipeline register; out_chan always 0.
//  - Grant may change between stalled cycles (nothing accepted); fairness is defined only over accepted beats.
//  - Arithmetic: index wrap via compare, not modulo; no width truncation of in_data slices.
// CONFIGURATION
//  MUX_PKT_LOCK_EN defined:
//   - in_last/out_last ports exist.
//   - Accepting a beat with in_last[g]=0 sets lock=1 and lock_chan=g.
//   - While lock=1, grant is forced to lock_chan; other channels see in_ready=0 even if valid.
//   - Accepting a beat with in_last=1 clears lock. rr_ptr still advances per accepted beat.
//  MUX_PKT_LOCK_EN undefined:
//   - Ports absent; every beat is arbitrated independently; no lock state is synthesised.
// TESTING
//  1 Reset mid-stream: out_valid=1 held, rst_n low -> out_valid=0, out_data=0 immediately (async); rr_ptr=0 after release.
//  2 MODE0, SEL=4, WIDTH=8, in_valid=4'b1010, out_ready=1 -> ch1 (0x11) each clk, ch3 starved, out_chan=1, 1-clk latency.
//  3 MODE1, SEL=4, all valid, data=c*0x10, out_ready=1 -> out_chan sequence 0,1,2,3,0, one beat per clk.
//  4 Back-pressure: out_ready=0 for 5 clks with out_data=0x22 -> in_ready=0, out_data/out_chan stable; release -> next beat next clk.
//  5 Wrap: MODE1, rr_ptr=3, only ch0 and ch3 valid -> ch3 granted, then ch0, then ch3.
//  6 MUX_PKT_LOCK_EN: ch2 sends 3 beats, last on 3rd, while ch0 valid -> out_chan=2,2,2 then 0.

Source files
------------

// File: rtl/mux_arb_reg.sv
// Registered SEL-channel mux with valid/ready handshake and fixed-priority or round-robin arbitration.
// Optional packet lock (in_last/out_last) is built when MUX_PKT_LOCK_EN is defined.
module mux_arb_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL   = 4,
  parameter int unsigned MODE  = 1,
  localparam int unsigned NSEL = (SEL > 1) ? $clog2(SEL) : 1,
  localparam int unsigned IW   = NSEL + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL*WIDTH-1:0] in_data,
  input  logic [SEL-1:0]       in_valid,
  output logic [SEL-1:0]       in_ready,
`ifdef MUX_PKT_LOCK_EN
  input  logic [SEL-1:0]       in_last,
  output logic                 out_last,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic [NSEL-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [NSEL-1:0]  rr_ptr;
  logic [NSEL-1:0]  gnt;
  logic [NSEL-1:0]  rr_next;
  logic [IW-1:0]    idx;
  logic             found;
  logic             slot_free;
  logic             take;
  logic [WIDTH-1:0] sel_data;

`ifdef MUX_PKT_LOCK_EN
  logic            lock;
  logic [NSEL-1:0] lock_chan;
  logic            sel_last;
`endif

  // Grant search: from channel 0 (fixed priority) or from rr_ptr with compare-based wrap.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < SEL; i++) begin
      if (MODE == 0) begin
        idx = IW'(i);
      end else begin
        idx = {1'b0, rr_ptr} + IW'(i);
        if (idx >= IW'(SEL)) idx = idx - IW'(SEL);
      end
      if (!found && in_valid[NSEL'(idx)]) begin
        found = 1'b1;
        gnt   = NSEL'(idx);
      end
    end
`ifdef MUX_PKT_LOCK_EN
    if (lock) begin
      gnt   = lock_chan;
      found = in_valid[lock_chan];
    end
`endif
  end

  // Data (and last) selection with constant slice offsets.
  always_comb begin
    sel_data = '0;
`ifdef MUX_PKT_LOCK_EN
    sel_last = 1'b0;
`endif
    for (int unsigned c = 0; c < SEL; c++) begin
      if (gnt == NSEL'(c)) begin
        sel_data = in_data[c*WIDTH +: WIDTH];
`ifdef MUX_PKT_LOCK_EN
        sel_last = in_last[c];
`endif
      end
    end
  end

  always_comb begin
    slot_free = !out_valid || out_ready;
    take      = rst_n && slot_free && found;
    in_ready  = take ? (SEL'(1) << gnt) : '0;
    rr_next   = (gnt == NSEL'(SEL - 1)) ? '0 : NSEL'(gnt + 1'b1);
  end

  // Output register: reload on input transfer, drain on output-only transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= gnt;
      rr_ptr    <= rr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  // Packet lock: a non-last beat pins the grant to its channel until the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock      <= 1'b0;
      lock_chan <= '0;
      out_last  <= 1'b0;
    end else if (take) begin
      lock      <= !sel_last;
      lock_chan <= gnt;
      out_last  <= sel_last;
    end
  end
`endif

endmodule
